// File: rtl/alu_arith_pkg.sv
// alu_arith_pkg: shared types for the sequential arithmetic unit.
// Holds the op code enum, the {c,n,v,z} flag bundle and FSM states.
package alu_arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADC  = 3'b010,
        OP_SBB  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef struct packed {
        logic c;
        logic n;
        logic v;
        logic z;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/alu_mul_shiftadd.sv
// alu_mul_shiftadd: unsigned shift-add multiplier, one step per clock.
// Ports: clk, rst_n (sync, active-low), start, a, b -> done, prod.
// done is high during the last step; prod then holds the final product.
module alu_mul_shiftadd #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 busy;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    always_comb begin
        acc_nx = acc;
        if (mplier[0]) begin
            acc_nx = acc + mcand;
        end
    end

    // prod exposes the post-step sum so the caller can latch it
    // on the same edge as the final step.
    assign done = busy && (cnt == CNT_W'(WIDTH - 1));
    assign prod = acc_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_arith_seq.sv
// alu_arith_seq: registered add/sub/adc/sbb/inc/dec/pass/mul with
// valid/ready on input (in_valid/in_ready, op, a, b, c_in) and output
// (out_valid/out_ready, result, result_hi, flags {c,n,v,z}).
// Macro ALU_ARITH_MUL_EN enables the multi-cycle multiplier; without
// it, MUL completes in one cycle with zero result and flags.
module alu_arith_seq
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  op_e               op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output flags_t            flags
);

    state_e state, state_nx;
    logic   accept;
    logic   mul_op;

    logic [WIDTH-1:0] opa, opb, alu_r;
    logic             cin;
    logic [WIDTH:0]   sum;
    flags_t           alu_f;

    assign accept = in_valid && in_ready;

`ifdef ALU_ARITH_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   prod_hi, prod_lo;

    assign mul_op  = (op == OP_MUL);
    assign prod_hi = prod[2*WIDTH-1:WIDTH];
    assign prod_lo = prod[WIDTH-1:0];

    alu_mul_shiftadd #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && mul_op),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (prod)
    );
`else
    assign mul_op = 1'b0;
`endif

    // Single adder; SUB/SBB feed ~b so c=1 means no borrow.
    always_comb begin
        opa = a;
        opb = '0;
        cin = 1'b0;
        unique case (op)
            OP_ADD: opb = b;
            OP_SUB: begin
                opb = ~b;
                cin = 1'b1;
            end
            OP_ADC: begin
                opb = b;
                cin = c_in;
            end
            OP_SBB: begin
                opb = ~b;
                cin = c_in;
            end
            OP_INC: cin = 1'b1;
            OP_DEC: opb = '1;
            default: ;
        endcase
        sum     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        alu_r   = sum[WIDTH-1:0];
        alu_f.c = sum[WIDTH];
        alu_f.n = alu_r[WIDTH-1];
        alu_f.v = (opa[WIDTH-1] == opb[WIDTH-1])
               && (alu_r[WIDTH-1] != opa[WIDTH-1]);
        alu_f.z = (alu_r == '0);
        if (op == OP_PASS) begin
            alu_r   = a;
            alu_f.c = 1'b0;
            alu_f.n = a[WIDTH-1];
            alu_f.v = 1'b0;
            alu_f.z = (a == '0);
        end
        if (op == OP_MUL) begin
            alu_r = '0;
            alu_f = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = mul_op ? BUSY : DONE;
                end
            end
            BUSY: begin
`ifdef ALU_ARITH_MUL_EN
                if (mul_done) begin
                    state_nx = DONE;
                end
`else
                state_nx = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result registers only change on completion; held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else if (accept && !mul_op) begin
            result    <= alu_r;
            result_hi <= '0;
            flags     <= alu_f;
`ifdef ALU_ARITH_MUL_EN
        end else if ((state == BUSY) && mul_done) begin
            result    <= prod_lo;
            result_hi <= prod_hi;
            flags.c   <= |prod_hi;
            flags.n   <= prod_lo[WIDTH-1];
            flags.v   <= |prod_hi;
            flags.z   <= (prod == '0);
`endif
        end
    end

endmodule

// File: tb/tb_alu_arith_seq.sv
// tb_alu_arith_seq: directed vectors against a plain-arithmetic model,
// checked every cycle by one compare process.
module tb_alu_arith_seq;
    import alu_arith_pkg::*;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    op_e        op = OP_ADD;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [7:0] result_hi;
    flags_t     flags;

    always #5 clk = ~clk;

    alu_arith_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [3:0] f;
        int         acc;
        int         lat;
        bit         lit;
        logic [7:0] lhi;
        logic [7:0] llo;
        logic [3:0] lf;
    } exp_t;

    exp_t q [0:63];
    int   n_sent = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   was_rst = 1'b1;
    bit   first = 1'b1;

    always @(posedge clk) cyc++;

    function automatic exp_t model(op_e o, int x, int y, int ci);
        exp_t e;
        int   u, s, sx, sy, p;
        bit   c, v;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        u = 0;
        s = 0;
        p = 0;
        e.hi = 8'h00;
        e.lat = 1;
        e.acc = 0;
        e.lit = 1'b0;
        e.lhi = 8'h00;
        e.llo = 8'h00;
        e.lf = 4'h0;
        case (o)
            OP_ADD: begin u = x + y;            s = sx + sy;          end
            OP_SUB: begin u = x + 256 - y;      s = sx - sy;          end
            OP_ADC: begin u = x + y + ci;       s = sx + sy + ci;     end
            OP_SBB: begin u = x + 255 - y + ci; s = sx - sy - 1 + ci; end
            OP_INC: begin u = x + 1;            s = sx + 1;           end
            OP_DEC: begin u = x + 255;          s = sx - 1;           end
            default: ;
        endcase
        e.lo = 8'(u % 256);
        c = (u >= 256);
        v = (s > 127) || (s < -128);
        e.f = {c, e.lo[7], v, e.lo == 8'h00};
        if (o == OP_PASS) begin
            e.lo = 8'(x);
            e.f = {1'b0, e.lo[7], 1'b0, e.lo == 8'h00};
        end
        if (o == OP_MUL) begin
`ifdef ALU_ARITH_MUL_EN
            p = x * y;
            e.hi = 8'(p / 256);
            e.lo = 8'(p % 256);
            e.f = {e.hi != 8'h00, e.lo[7], e.hi != 8'h00, p == 0};
            e.lat = W + 1;
`else
            e.lo = 8'h00;
            e.f = 4'h0;
`endif
        end
        return e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        bit   open;
        if (!rst_n) begin
            n_done = n_sent;
            was_rst = 1'b1;
            first = 1'b1;
        end else begin
            if (was_rst) begin
                checks++;
                if ({result_hi, result, flags, out_valid, in_ready}
                    !== {8'h00, 8'h00, 4'h0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL reset_state got hi=%h lo=%h f=%b ov=%b ir=%b required 00 00 0000 0 1",
                             result_hi, result, flags, out_valid, in_ready);
                end
                was_rst = 1'b0;
            end
            open = (n_done != n_sent);
            checks++;
            if (in_ready !== !open) begin
                errors++;
                $display("FAIL in_ready cyc=%0d got=%b required=%b", cyc, in_ready, !open);
            end
            if (!open) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL out_valid_idle cyc=%0d got=%b required=0", cyc, out_valid);
                end
            end else begin
                e = q[n_done % 64];
                if (out_valid !== 1'b1) begin
                    checks++;
                    if (cyc - e.acc >= e.lat - 1) begin
                        errors++;
                        $display("FAIL out_valid_late txn=%0d got=%b required=1 after %0d cycles",
                                 n_done, out_valid, e.lat);
                    end
                end else begin
                    if (first) begin
                        checks++;
                        if (cyc - e.acc != e.lat - 1) begin
                            errors++;
                            $display("FAIL latency txn=%0d got=%0d required=%0d",
                                     n_done, cyc - e.acc + 1, e.lat);
                        end
                        if (e.lit) begin
                            checks++;
                            if ({result_hi, result, flags} !== {e.lhi, e.llo, e.lf}) begin
                                errors++;
                                $display("FAIL literal txn=%0d got hi=%h lo=%h f=%b required hi=%h lo=%h f=%b",
                                         n_done, result_hi, result, flags, e.lhi, e.llo, e.lf);
                            end
                        end
                        first = 1'b0;
                    end
                    checks++;
                    if ({result_hi, result, flags} !== {e.hi, e.lo, e.f}) begin
                        errors++;
                        $display("FAIL model txn=%0d got hi=%h lo=%h f=%b required hi=%h lo=%h f=%b",
                                 n_done, result_hi, result, flags, e.hi, e.lo, e.f);
                    end
                    if (out_ready) begin
                        n_done++;
                        first = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input op_e o, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input bit lit = 1'b0,
                        input logic [7:0] lhi = 8'h00, input logic [7:0] llo = 8'h00,
                        input logic [3:0] lf = 4'h0);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL send_wait got in_ready=%b required=1", in_ready);
            $fatal(1);
        end
        op = o;
        a = x;
        b = y;
        c_in = ci;
        in_valid = 1'b1;
        e = model(o, int'(x), int'(y), int'(ci));
        e.acc = cyc + 1;
        e.lit = lit;
        e.lhi = lhi;
        e.llo = llo;
        e.lf = lf;
        @(posedge clk);
        #1;
        q[n_sent % 64] = e;
        n_sent++;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = op_e'($urandom_range(0, 7));
        c_in = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (n_done != n_sent && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n_done != n_sent) begin
            $display("FAIL drain got pending=%0d required=0", n_sent - n_done);
            $fatal(1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h00, 8'h80, 4'b0110);
        send(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 8'hFF, 4'b0100);
        send(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 4'b1001);
        send(OP_ADC, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 4'b1001);
        send(OP_SBB, 8'h10, 8'h01, 1'b0, 1'b1, 8'h00, 8'h0E, 4'b1000);
        send(OP_INC, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 4'b1001);
        send(OP_DEC, 8'h00, 8'h33, 1'b1);
        send(OP_DEC, 8'h80, 8'h00, 1'b0);
        send(OP_PASS, 8'h80, 8'h7F, 1'b1);
        send(OP_PASS, 8'h00, 8'hFF, 1'b1);
        send(OP_ADC, 8'h7F, 8'h00, 1'b1);
        send(OP_SBB, 8'h80, 8'h01, 1'b1);
        send(OP_ADD, 8'hC0, 8'hC0, 1'b1);
`ifdef ALU_ARITH_MUL_EN
        send(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFE, 8'h01, 4'b1010);
`else
        send(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000);
`endif
        send(OP_MUL, 8'h00, 8'h5A, 1'b0);
        send(OP_MUL, 8'h0D, 8'h0B, 1'b0);
        drain();

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(OP_ADD, 8'h03, 8'h04, 1'b0, 1'b1, 8'h00, 8'h07, 4'b0000);
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_SUB;
        a = 8'h55;
        b = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        send(OP_MUL, 8'hC3, 8'h5A, 1'b0);
`ifdef ALU_ARITH_MUL_EN
        in_valid = 1'b1;
        op = OP_ADD;
        a = 8'h01;
        b = 8'h01;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;

        send(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b1, 8'h00, 8'h46, 4'b0000);
        drain();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
